// File: rtl/seg_scan_driver_if.sv
// seg_scan_driver_if: display data bus and scanned pin outputs for seg_scan_driver.
// master = display data register side, slave = scan driver.
interface seg_scan_driver_if #(
  parameter int unsigned DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   data_in;
  logic [DIGITS-1:0]     dp_in;
  logic [DIGITS-1:0]     blank_in;
  logic [6:0]            seg_out;
  logic                  dp_out;
  logic [DIGITS-1:0]     digit_sel;
  logic                  frame_tick;

  modport master (
    output load, data_in, dp_in, blank_in,
    input  seg_out, dp_out, digit_sel, frame_tick
  );

  modport slave (
    input  load, data_in, dp_in, blank_in,
    output seg_out, dp_out, digit_sel, frame_tick
  );
endinterface

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment driver for DIGITS digits.
// Holds a shadow copy of the digit data and scans one digit per SCAN_DIV
// cycles, with DEAD_CYC dark cycles at the start of each dwell.
// Optional feature macro: LEADING_ZERO_BLANK_EN (leading-zero suppression).
module seg_scan_driver #(
  parameter int unsigned DIGITS         = 4,
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned DEAD_CYC       = 2,
  parameter bit          SEG_ACTIVE_LOW = 1'b0,
  parameter bit          SEL_ACTIVE_LOW = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  seg_scan_driver_if.slave bus
);

  localparam int unsigned PRESC_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned PTR_W   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned DATA_W  = 4 * DIGITS;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0]  data_q;
  logic [DIGITS-1:0]  dp_q;
  logic [DIGITS-1:0]  blank_q;

  logic [6:0]         seg_q, seg_d;
  logic               dp_out_q, dp_out_d;
  logic [DIGITS-1:0]  sel_q, sel_d;
  logic               tick_q, tick_d;

  logic               presc_last_c;
  logic               ptr_last_c;
  logic               dead_c;
  logic [3:0]         cur_nib_c;
  logic               cur_dp_c;
  logic               cur_blank_c;
  logic               cur_supp_c;
  logic [DIGITS-1:0]  cur_onehot_c;
  logic [6:0]         dec_c;
  logic [6:0]         seg_log_c;
  logic               dp_log_c;
  logic [DIGITS-1:0]  sel_log_c;

  // Prescaler and digit pointer next state.
  always_comb begin
    presc_last_c = (presc_q == PRESC_W'(SCAN_DIV - 1));
    ptr_last_c   = (ptr_q == PTR_W'(DIGITS - 1));
    presc_d      = presc_q + PRESC_W'(1);
    ptr_d        = ptr_q;
    if (presc_last_c) begin
      presc_d = '0;
      ptr_d   = ptr_last_c ? '0 : ptr_q + PTR_W'(1);
    end
  end

  // Wrap from the last digit back to digit 0 marks a frame boundary.
  assign tick_d = presc_last_c & ptr_last_c;

  // Dead-time window at the start of every dwell.
  if (DEAD_CYC == 0) begin : g_no_dead
    assign dead_c = 1'b0;
  end else begin : g_dead
    assign dead_c = (presc_q < PRESC_W'(DEAD_CYC));
  end

  // Pick the shadow fields of the digit under the pointer.
  always_comb begin
    cur_nib_c    = 4'h0;
    cur_dp_c     = 1'b0;
    cur_blank_c  = 1'b0;
    cur_onehot_c = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (ptr_q == PTR_W'(i)) begin
        cur_nib_c       = data_q[4*i +: 4];
        cur_dp_c        = dp_q[i];
        cur_blank_c     = blank_q[i];
        cur_onehot_c[i] = 1'b1;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] supp_c;

  // A digit is suppressed while every digit from the top down to it is zero; digit 0 never is.
  always_comb begin
    logic zero_run;
    zero_run = 1'b1;
    supp_c   = '0;
    for (int i = int'(DIGITS) - 1; i >= 1; i--) begin
      zero_run  = zero_run & (data_q[4*i +: 4] == 4'h0);
      supp_c[i] = zero_run;
    end
  end

  assign cur_supp_c = |(supp_c & cur_onehot_c);
`else
  assign cur_supp_c = 1'b0;
`endif

  // Hex to {a,b,c,d,e,f,g}, active-high.
  always_comb begin
    dec_c = 7'h00;
    case (cur_nib_c)
      4'h0: dec_c = 7'h7E;
      4'h1: dec_c = 7'h30;
      4'h2: dec_c = 7'h6D;
      4'h3: dec_c = 7'h79;
      4'h4: dec_c = 7'h33;
      4'h5: dec_c = 7'h5B;
      4'h6: dec_c = 7'h5F;
      4'h7: dec_c = 7'h70;
      4'h8: dec_c = 7'h7F;
      4'h9: dec_c = 7'h73;
      4'hA: dec_c = 7'h77;
      4'hB: dec_c = 7'h1F;
      4'hC: dec_c = 7'h4E;
      4'hD: dec_c = 7'h3D;
      4'hE: dec_c = 7'h4F;
      4'hF: dec_c = 7'h47;
      default: dec_c = 7'h00;
    endcase
  end

  // Logical pin values; blanking darkens segments and dp but keeps the digit selected.
  always_comb begin
    sel_log_c = '0;
    seg_log_c = 7'h00;
    dp_log_c  = 1'b0;
    if (!dead_c) begin
      sel_log_c = cur_onehot_c;
      if (!cur_blank_c) begin
        dp_log_c = cur_dp_c;
        if (!cur_supp_c) begin
          seg_log_c = dec_c;
        end
      end
    end
  end

  assign seg_d    = seg_log_c ^ {7{SEG_ACTIVE_LOW}};
  assign dp_out_d = dp_log_c ^ SEG_ACTIVE_LOW;
  assign sel_d    = sel_log_c ^ {DIGITS{SEL_ACTIVE_LOW}};

  // Scan timing state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
      ptr_q   <= '0;
    end else begin
      presc_q <= presc_d;
      ptr_q   <= ptr_d;
    end
  end

  // Shadow copy of the display data, captured on load.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      dp_q    <= '0;
      blank_q <= '0;
    end else if (bus.load) begin
      data_q  <= bus.data_in;
      dp_q    <= bus.dp_in;
      blank_q <= bus.blank_in;
    end
  end

  // Pin registers; reset drives the physical off level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg_q    <= {7{SEG_ACTIVE_LOW}};
      dp_out_q <= SEG_ACTIVE_LOW;
      sel_q    <= {DIGITS{SEL_ACTIVE_LOW}};
      tick_q   <= 1'b0;
    end else begin
      seg_q    <= seg_d;
      dp_out_q <= dp_out_d;
      sel_q    <= sel_d;
      tick_q   <= tick_d;
    end
  end

  assign bus.seg_out    = seg_q;
  assign bus.dp_out     = dp_out_q;
  assign bus.digit_sel  = sel_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: checks seg_scan_driver (4 digits, SCAN_DIV=4, DEAD_CYC=1)
// with plain pin polarity and with both pin inversions on a second instance.
module tb_seg_scan_driver;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int DC    = 1;
  localparam int FRAME = ND * SD;

`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  localparam logic [6:0] LZ7 = LZB ? 7'h00 : 7'h7E;

  localparam logic [6:0] DEC [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                      7'h7F, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  localparam logic [3:0] SCAN_SEQ [17] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2,
                                           4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] data_in = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_in = '0;

  always #5 clk = ~clk;

  seg_scan_driver_if #(.DIGITS(ND)) bus_a ();
  seg_scan_driver_if #(.DIGITS(ND)) bus_b ();

  assign bus_a.load = load;  assign bus_a.data_in = data_in;
  assign bus_a.dp_in = dp_in; assign bus_a.blank_in = blank_in;
  assign bus_b.load = load;  assign bus_b.data_in = data_in;
  assign bus_b.dp_in = dp_in; assign bus_b.blank_in = blank_in;

  seg_scan_driver #(.DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC),
                    .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0))
    u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));

  seg_scan_driver #(.DIGITS(ND), .SCAN_DIV(SD), .DEAD_CYC(DC),
                    .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1))
    u_dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // t counts cycles since reset release; phase and digit follow by arithmetic.
  int          t;
  logic [15:0] m_data;
  logic [3:0]  m_dp, m_bl;
  logic [3:0]  e_sel;
  logic [6:0]  e_seg;
  logic        e_dp, e_tick;
  bit          mon_en = 1'b0;

  function automatic bit lz_supp(logic [15:0] d, int dg);
    if (!LZB || dg == 0) return 1'b0;
    for (int i = ND - 1; i >= dg; i--) begin
      if (d[4*i +: 4] != 4'h0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic bit in_dead(int tt);
    return (tt % SD) < DC;
  endfunction

  function automatic int dig_of(int tt);
    return (tt / SD) % ND;
  endfunction

  function automatic logic [3:0] exp_sel(int tt);
    logic [3:0] s;
    s = '0;
    if (!in_dead(tt)) s[dig_of(tt)] = 1'b1;
    return s;
  endfunction

  function automatic logic [6:0] exp_seg(int tt, logic [15:0] d, logic [3:0] bl);
    int dg;
    dg = dig_of(tt);
    if (in_dead(tt) || bl[dg] || lz_supp(d, dg)) return 7'h00;
    return DEC[d[4*dg +: 4]];
  endfunction

  function automatic logic exp_dp(int tt, logic [3:0] dp, logic [3:0] bl);
    int dg;
    dg = dig_of(tt);
    if (in_dead(tt) || bl[dg]) return 1'b0;
    return dp[dg];
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      t      <= 0;
      m_data <= '0;
      m_dp   <= '0;
      m_bl   <= '0;
      e_sel  <= '0;
      e_seg  <= '0;
      e_dp   <= 1'b0;
      e_tick <= 1'b0;
    end else begin
      e_sel  <= exp_sel(t);
      e_seg  <= exp_seg(t, m_data, m_bl);
      e_dp   <= exp_dp(t, m_dp, m_bl);
      e_tick <= ((t + 1) % FRAME) == 0;
      t      <= t + 1;
      if (load) begin
        m_data <= data_in;
        m_dp   <= dp_in;
        m_bl   <= blank_in;
      end
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    logic [6:0] inv_seg;
    logic [3:0] inv_sel;
    logic       inv_dp;
    if (mon_en) begin
      inv_seg = ~e_seg;
      inv_sel = ~e_sel;
      inv_dp  = ~e_dp;
      check("mon_a_sel", bus_a.digit_sel, e_sel);
      check("mon_a_seg", bus_a.seg_out, e_seg);
      check("mon_a_dp", bus_a.dp_out, e_dp);
      check("mon_a_tick", bus_a.frame_tick, e_tick);
      check("mon_b_sel", bus_b.digit_sel, inv_sel);
      check("mon_b_seg", bus_b.seg_out, inv_seg);
      check("mon_b_dp", bus_b.dp_out, inv_dp);
      check("mon_b_tick", bus_b.frame_tick, e_tick);
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check_reset_pins(string tag);
    check({tag, "_a_sel"}, bus_a.digit_sel, 4'h0);
    check({tag, "_a_seg"}, bus_a.seg_out, 7'h00);
    check({tag, "_a_dp"}, bus_a.dp_out, 1'b0);
    check({tag, "_a_tick"}, bus_a.frame_tick, 1'b0);
    check({tag, "_b_sel"}, bus_b.digit_sel, 4'hF);
    check({tag, "_b_seg"}, bus_b.seg_out, 7'h7F);
    check({tag, "_b_dp"}, bus_b.dp_out, 1'b1);
    check({tag, "_b_tick"}, bus_b.frame_tick, 1'b0);
  endtask

  // Caller has just released rst_n at a negedge with cleared shadow data.
  task automatic scan_check(string tag);
    for (int k = 1; k <= 17; k++) begin
      @(negedge clk);
      check({tag, "_sel"}, bus_a.digit_sel, SCAN_SEQ[k-1]);
      check({tag, "_tick"}, bus_a.frame_tick, 32'(k == 16));
      if (k == 2) check({tag, "_d0_zero"}, bus_a.seg_out, 7'h7E);
    end
  endtask

  task automatic wait_state(int ph, int dg);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 64; c++) begin
      if ((t % SD) == ph && dig_of(t) == dg) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wait_state", ok, 1);
  endtask

  function automatic logic [15:0] rnd_data();
    logic [15:0] d;
    for (int i = 0; i < ND; i++)
      d[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
    return d;
  endfunction

  typedef struct {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  bl;
    int          dg;
    logic [6:0]  seg;
    logic        dpx;
  } vec_t;

  localparam int NV = 26;
  vec_t vt [NV];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         found;
    logic [6:0] inv;

    vt[0]  = '{16'h0123, 4'h0, 4'h0, 0, 7'h79, 1'b0};
    vt[1]  = '{16'h0123, 4'h0, 4'h0, 1, 7'h6D, 1'b0};
    vt[2]  = '{16'h0123, 4'h0, 4'h0, 2, 7'h30, 1'b0};
    vt[3]  = '{16'h4567, 4'h0, 4'h0, 0, 7'h70, 1'b0};
    vt[4]  = '{16'h4567, 4'h0, 4'h0, 1, 7'h5F, 1'b0};
    vt[5]  = '{16'h4567, 4'h0, 4'h0, 2, 7'h5B, 1'b0};
    vt[6]  = '{16'h4567, 4'h0, 4'h0, 3, 7'h33, 1'b0};
    vt[7]  = '{16'h89AB, 4'h0, 4'h0, 0, 7'h1F, 1'b0};
    vt[8]  = '{16'h89AB, 4'h0, 4'h0, 1, 7'h77, 1'b0};
    vt[9]  = '{16'h89AB, 4'h0, 4'h0, 2, 7'h73, 1'b0};
    vt[10] = '{16'h89AB, 4'h0, 4'h0, 3, 7'h7F, 1'b0};
    vt[11] = '{16'hCDEF, 4'h0, 4'h0, 0, 7'h47, 1'b0};
    vt[12] = '{16'hCDEF, 4'h0, 4'h0, 1, 7'h4F, 1'b0};
    vt[13] = '{16'hCDEF, 4'h0, 4'h0, 2, 7'h3D, 1'b0};
    vt[14] = '{16'hCDEF, 4'h0, 4'h0, 3, 7'h4E, 1'b0};
    vt[15] = '{16'h1234, 4'h2, 4'h4, 1, 7'h79, 1'b1};
    vt[16] = '{16'h1234, 4'h2, 4'h4, 2, 7'h00, 1'b0};
    vt[17] = '{16'h0070, 4'h0, 4'h0, 3, LZ7,   1'b0};
    vt[18] = '{16'h0070, 4'h0, 4'h0, 2, LZ7,   1'b0};
    vt[19] = '{16'h0070, 4'h0, 4'h0, 1, 7'h70, 1'b0};
    vt[20] = '{16'h0070, 4'h0, 4'h0, 0, 7'h7E, 1'b0};
    vt[21] = '{16'h0005, 4'h8, 4'h0, 3, LZ7,   1'b1};
    vt[22] = '{16'h0000, 4'h0, 4'h0, 0, 7'h7E, 1'b0};
    vt[23] = '{16'h0800, 4'h0, 4'h4, 2, 7'h00, 1'b0};
    vt[24] = '{16'h1005, 4'h0, 4'h0, 2, 7'h7E, 1'b0};
    vt[25] = '{16'h1111, 4'h4, 4'h4, 2, 7'h00, 1'b0};

    // Reset state on both polarities.
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    check_reset_pins("reset");

    // Scan order and frame tick after release.
    rst_n = 1'b1;
    scan_check("scan");

    // Decode, dp, blank and suppression vectors.
    for (int v = 0; v < NV; v++) begin
      @(negedge clk);
      load = 1'b1; data_in = vt[v].data; dp_in = vt[v].dp; blank_in = vt[v].bl;
      @(negedge clk);
      load = 1'b0;
      @(negedge clk);
      found = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (bus_a.digit_sel == 4'(1 << vt[v].dg)) begin
          found = 1'b1;
          break;
        end
        @(negedge clk);
      end
      check($sformatf("vec%0d_found", v), found, 1);
      if (found) begin
        inv = ~vt[v].seg;
        check($sformatf("vec%0d_seg", v), bus_a.seg_out, vt[v].seg);
        check($sformatf("vec%0d_dp", v), bus_a.dp_out, vt[v].dpx);
        check($sformatf("vec%0d_b_seg", v), bus_b.seg_out, inv);
      end
    end

    // Load on the same edge as the advance from digit 1 to digit 2.
    @(negedge clk);
    load = 1'b1; data_in = 16'h1111; dp_in = 4'h0; blank_in = 4'h0;
    @(negedge clk);
    load = 1'b0;
    wait_state(SD - 1, 1);
    load = 1'b1; data_in = 16'h0A05;
    @(negedge clk);
    load = 1'b0;
    @(negedge clk);
    check("adv_dead_sel", bus_a.digit_sel, 4'h0);
    @(negedge clk);
    check("adv_sel", bus_a.digit_sel, 4'h4);
    check("adv_seg", bus_a.seg_out, 7'h77);

    // Reset mid-dwell at digit 2, with a load offered during reset.
    wait_state(2, 2);
    rst_n = 1'b0;
    load = 1'b1; data_in = 16'hFFFF; dp_in = 4'hF;
    @(negedge clk);
    check_reset_pins("midrst");
    rst_n = 1'b1;
    load = 1'b0;
    scan_check("rescan");

    // Randomized loads and occasional resets against the model.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      load = ($urandom_range(0, 7) == 0);
      if (load) begin
        data_in  = rnd_data();
        dp_in    = 4'($urandom_range(0, 15));
        blank_in = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
      end
      rst_n = ($urandom_range(0, 299) != 0);
    end
    @(negedge clk);
    load  = 1'b0;
    rst_n = 1'b1;
    repeat (FRAME) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
